// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq: walks a command ROM and feeds write-only transactions to an i2c byte master.
//
// Each ROM entry is {last, byte}; last marks the final byte of a transaction, and the
// final ROM entry always closes its transaction. Every transaction goes to DEV_ADDR.
// The sequence stops early and flags o_error when the master reports a NACK.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   i_start          start pulse, honoured in IDLE/DONE (or the cycle DONE is reached)
//   o_seq_busy       high from accepted start until DONE
//   o_done           high in DONE, cleared by the next start
//   o_error          a transaction was NACKed (valid while o_done)
//   o_rom_addr       ROM read address; i_rom_data follows one clock later
//   i_rom_data       {last, byte}
//   o_i2c_enable     request/continue a transaction on the master
//   o_i2c_addr       slave address (DEV_ADDR)
//   o_i2c_rw         always write
//   o_i2c_data_wr    byte presented to the master
//   i_i2c_busy       master busy; each falling edge ends one shifted byte
//   i_i2c_ready      master idle
//   i_i2c_ack_error  master NACK flag, cleared by the master at each START
module i2c_cmd_seq #(
    parameter int         CLK_FREQ     = 12_000_000,
    parameter logic [6:0] DEV_ADDR     = 7'h3C,
    parameter int         ROM_LEN      = 32,
    parameter int         AW           = 8,
    parameter int         PWRUP_CYCLES = CLK_FREQ / 10_000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    output logic          o_seq_busy,
    output logic          o_done,
    output logic          o_error,
    output logic [AW-1:0] o_rom_addr,
    input  logic [8:0]    i_rom_data,
    output logic          o_i2c_enable,
    output logic [6:0]    o_i2c_addr,
    output logic          o_i2c_rw,
    output logic [7:0]    o_i2c_data_wr,
    input  logic          i_i2c_busy,
    input  logic          i_i2c_ready,
    input  logic          i_i2c_ack_error
);
    typedef enum logic [2:0] {
        S_IDLE, S_PWRUP, S_FETCH, S_ARM, S_SEND, S_WAITIDLE, S_DONE
    } state_t;

    localparam int            CW       = $clog2(PWRUP_CYCLES + 1);
    localparam logic [CW-1:0] PW_LAST  = CW'(PWRUP_CYCLES - 1);
    localparam logic [AW-1:0] ROM_LAST = AW'(ROM_LEN - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_last;
    logic          r_fwait;
    logic [1:0]    r_ld;
    logic          w_fall;
    logic          w_rom_end;
    logic          w_fin;
    logic          w_restart;

    assign o_i2c_addr = DEV_ADDR;
    assign o_i2c_rw   = 1'b0;
    assign w_fall     = r_busy & ~i_i2c_busy;
    assign w_rom_end  = o_rom_addr == ROM_LAST;
    // WAITIDLE exit that ends the whole list: NACK seen or ROM exhausted
    assign w_fin      = i_i2c_ready & (i_i2c_ack_error | w_rom_end);
    // a start landing on the very cycle DONE would be reached restarts instead
    assign w_restart  = i_start & (r_state == S_IDLE || r_state == S_DONE ||
                                   (r_state == S_WAITIDLE && w_fin));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_last        <= 1'b0;
            r_fwait       <= 1'b0;
            r_ld          <= '0;
            o_seq_busy    <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            o_rom_addr    <= '0;
            o_i2c_enable  <= 1'b0;
            o_i2c_data_wr <= '0;
        end else begin
            r_busy <= i_i2c_busy;
            // two-stage delay: address bump, ROM latency, then latch the next byte
            r_ld   <= {r_ld[0], 1'b0};
            if (w_restart) begin
                r_state    <= S_PWRUP;
                r_cnt      <= '0;
                o_rom_addr <= '0;
                o_seq_busy <= 1'b1;
                o_done     <= 1'b0;
                o_error    <= 1'b0;
            end else begin
                case (r_state)
                    S_PWRUP: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == PW_LAST) begin
                            r_state <= S_FETCH;
                            r_fwait <= 1'b0;
                        end
                    end
                    S_FETCH: begin
                        r_fwait <= 1'b1;
                        if (r_fwait) begin
                            o_i2c_data_wr <= i_rom_data[7:0];
                            r_last        <= i_rom_data[8] | w_rom_end;
                            if (i_i2c_ready) begin
                                r_state      <= S_ARM;
                                o_i2c_enable <= 1'b1;
                            end
                        end
                    end
                    // a busy fall while still in ARM is the first byte's edge
                    S_ARM, S_SEND: begin
                        if (r_ld[1]) begin
                            o_i2c_data_wr <= i_rom_data[7:0];
                            r_last        <= i_rom_data[8] | w_rom_end;
                        end
                        if (w_fall) begin
                            if (r_last) begin
                                o_i2c_enable <= 1'b0;
                                r_state      <= S_WAITIDLE;
                            end else begin
                                o_rom_addr <= o_rom_addr + 1'b1;
                                r_ld[0]    <= 1'b1;
                                r_state    <= S_SEND;
                            end
                        end
                    end
                    S_WAITIDLE: begin
                        if (w_fin) begin
                            r_state    <= S_DONE;
                            o_done     <= 1'b1;
                            o_seq_busy <= 1'b0;
                            o_error    <= i_i2c_ack_error;
                        end else if (i_i2c_ready) begin
                            o_rom_addr <= o_rom_addr + 1'b1;
                            r_state    <= S_FETCH;
                            r_fwait    <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_cmd_seq.sv
// tb_i2c_cmd_seq: scoreboard bench with a behavioural i2c byte master.
module tb_i2c_cmd_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       seq_busy, done, error, i2c_enable, i2c_rw;
    logic [7:0] rom_addr, i2c_data_wr;
    logic [6:0] i2c_addr;
    logic [8:0] rom_data = '0;
    logic       busy = 1'b0, ready = 1'b1, ack_err = 1'b0;
    logic [8:0] rom [8];
    logic [8:0] exp_q [$];
    int         n_vec = 0, n_err = 0, m_txn = 0, nack_txn = -1, n, base;
    bit         sb_on = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr[2:0]];

    i2c_cmd_seq #(
        .CLK_FREQ(12_000_000), .DEV_ADDR(7'h3C), .ROM_LEN(6), .AW(8), .PWRUP_CYCLES(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start),
        .o_seq_busy(seq_busy), .o_done(done), .o_error(error),
        .o_rom_addr(rom_addr), .i_rom_data(rom_data),
        .o_i2c_enable(i2c_enable), .o_i2c_addr(i2c_addr), .o_i2c_rw(i2c_rw),
        .o_i2c_data_wr(i2c_data_wr), .i_i2c_busy(busy), .i_i2c_ready(ready),
        .i_i2c_ack_error(ack_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int cnt);
        for (int i = 0; i < cnt; i++) exp_q.push_back({rom[i][8] | (i == 5), rom[i][7:0]});
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check(tag, done, 1);
    endtask

    task automatic load3x2();
        rom[0] = 9'h001; rom[1] = 9'h102; rom[2] = 9'h003;
        rom[3] = 9'h104; rom[4] = 9'h005; rom[5] = 9'h106;
    endtask

    // behavioural master: one busy pulse per byte, data_wr read well after each fall
    initial begin : master
        logic [7:0] cap;
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (i2c_enable) begin
                ready = 1'b0;
                ack_err = 1'b0;
                cap = i2c_data_wr;
                repeat (3) @(negedge clk);
                busy = 1'b1;
                repeat (10) @(negedge clk);
                if (m_txn == nack_txn) ack_err = 1'b1;
                forever begin
                    repeat (9) @(negedge clk);
                    busy = 1'b0;
                    repeat (8) @(negedge clk);
                    if (sb_on) begin
                        e = exp_q.size() > 0 ? {1'b0, exp_q.pop_front()} : 10'h3FF;
                        check("sb_byte", {22'd0, 1'b0, !i2c_enable, cap}, {22'd0, e});
                    end
                    if (!i2c_enable) break;
                    cap = i2c_data_wr;
                    busy = 1'b1;
                end
                repeat (4) @(negedge clk);
                ready = 1'b1;
                m_txn++;
            end
        end
    end

    initial begin
        int k;
        for (int i = 0; i < 8; i++) rom[i] = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seq_busy", seq_busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_enable", i2c_enable, 0);
        check("rst_data_wr", i2c_data_wr, 0);
        check("i2c_addr", i2c_addr, 7'h3C);
        check("i2c_rw", i2c_rw, 0);
        rst_n = 1'b1;

        rom[0] = 9'h000; rom[1] = 9'h1AE; rom[2] = 9'h011;
        rom[3] = 9'h022; rom[4] = 9'h033; rom[5] = 9'h044;
        push_exp(6);
        base = m_txn;
        pulse_start();
        check("t1_seq_busy", seq_busy, 1);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!i2c_enable && n < 200);
        check("en_rise_clk", n, 52);
        wait_done("t1_done");
        check("t1_error", error, 0);
        check("t1_rom_addr", rom_addr, 5);
        check("t1_txns", m_txn - base, 2);
        check("t1_q_empty", exp_q.size(), 0);
        check("t1_seq_busy_end", seq_busy, 0);

        load3x2();
        push_exp(6);
        base = m_txn;
        pulse_start();
        check("t2_done_clr", done, 0);
        wait_done("t2_done");
        check("t2_error", error, 0);
        check("t2_rom_addr", rom_addr, 5);
        check("t2_txns", m_txn - base, 3);
        check("t2_q_empty", exp_q.size(), 0);

        base = m_txn;
        nack_txn = m_txn + 1;
        push_exp(4);
        pulse_start();
        wait_done("t3_done");
        check("t3_error", error, 1);
        check("t3_rom_addr", rom_addr, 3);
        check("t3_txns", m_txn - base, 2);
        check("t3_q_empty", exp_q.size(), 0);

        nack_txn = -1;
        base = m_txn;
        push_exp(6);
        pulse_start();
        check("t4_error_clr", error, 0);
        check("t4_done_clr", done, 0);
        check("t4_seq_busy", seq_busy, 1);
        wait_done("t4_done");
        check("t4_error", error, 0);
        check("t4_rom_addr", rom_addr, 5);
        check("t4_txns", m_txn - base, 3);
        check("t4_q_empty", exp_q.size(), 0);

        push_exp(6);
        pulse_start();
        k = 0;
        while (!busy && k < 500) begin
            @(posedge clk);
            k++;
        end
        while (busy && k < 500) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        check("t5_pre_rst_en", i2c_enable, 1);
        #2 rst_n = 1'b0;
        sb_on = 1'b0;
        #1;
        check("t5_rst_enable", i2c_enable, 0);
        check("t5_rst_data_wr", i2c_data_wr, 0);
        check("t5_rst_rom_addr", rom_addr, 0);
        check("t5_rst_seq_busy", seq_busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_error", error, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (!ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t5_master_idle", ready, 1);
        exp_q.delete();
        sb_on = 1'b1;

        base = m_txn;
        push_exp(6);
        pulse_start();
        wait_done("t6_done");
        check("t6_error", error, 0);
        check("t6_txns", m_txn - base, 3);
        check("t6_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
